// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_RESTORE,
    ST_REDIRECT
  } trap_state_e;

  typedef enum logic [1:0] {
    EV_EXC,
    EV_IRQ,
    EV_IRET
  } trap_kind_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSRs: software write port, hardware commit/restore port and read mux.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw_we_i,
  input  logic [11:0] sw_addr_i,
  input  logic [31:0] sw_wdata_i,
  input  logic        commit_i,
  input  logic [31:0] commit_epc_i,
  input  logic [31:0] commit_cause_i,
  input  logic [31:0] commit_tval_i,
  input  logic        restore_i,
  output logic [31:0] rdata_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;

  // Hardware updates are applied after the software write so they win per field.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    if (sw_we_i) begin
      case (sw_addr_i)
        CSR_MSTATUS: begin
          mie_d  = sw_wdata_i[MSTATUS_MIE];
          mpie_d = sw_wdata_i[MSTATUS_MPIE];
        end
        CSR_MTVEC:  mtvec_d  = sw_wdata_i;
        CSR_MEPC:   mepc_d   = sw_wdata_i & 32'hFFFF_FFFC;
        CSR_MCAUSE: mcause_d = sw_wdata_i;
        CSR_MTVAL:  mtval_d  = sw_wdata_i;
        default: ;
      endcase
    end
    if (commit_i) begin
      mepc_d   = commit_epc_i & 32'hFFFF_FFFC;
      mcause_d = commit_cause_i;
      mtval_d  = commit_tval_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
    if (restore_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (sw_addr_i)
      CSR_MSTATUS: begin
        rdata_o[MSTATUS_MIE]  = mie_q;
        rdata_o[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MTVEC:  rdata_o = mtvec_q;
      CSR_MEPC:   rdata_o = mepc_q;
      CSR_MCAUSE: rdata_o = mcause_q;
      CSR_MTVAL:  rdata_o = mtval_q;
      default: ;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry/return sequencer: drains the pipeline, commits CSRs, redirects PC.
// state    | meaning
// IDLE     | waiting for an exception, xRET or enabled interrupt in E
// DRAIN    | fetch stalled, D/E flushed, waiting for memory to go idle
// COMMIT   | trap CSRs written (mepc, mcause, mtval, MIE/MPIE)
// RESTORE  | xRET: MIE <- MPIE, MPIE <- 1
// REDIRECT | one-cycle PC redirect to trap vector or mepc
module trap_controller
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter int unsigned CODE_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validE,
  input  logic [31:0]       pcE,
  input  logic              exceptionE,
  input  logic [CODE_W-1:0] exceptionCodeE,
  input  logic [31:0]       trapValE,
  input  logic              iretE,
  input  logic              irqPending,
  input  logic [CODE_W-1:0] irqCode,
  input  logic              memIdle,
  input  logic              csrWe,
  input  logic [11:0]       csrAddr,
  input  logic [31:0]       csrWdata,
  output logic [31:0]       csrRdata,
  output logic              busy,
  output logic              stallF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              redirectValid,
  output logic [31:0]       redirectPc
);

  trap_state_e       state_q, state_d;
  trap_kind_e        kind_q, kind_d;
  logic [31:0]       pc_q, pc_d, tval_q, tval_d;
  logic [CODE_W-1:0] cause_q, cause_d;

  logic        commit, restore, mie, take_evt;
  logic [31:0] mtvec, mepc, vec_off, trap_target, commit_cause;

  trap_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_we_i       (csrWe),
    .sw_addr_i     (csrAddr),
    .sw_wdata_i    (csrWdata),
    .commit_i      (commit),
    .commit_epc_i  (pc_q),
    .commit_cause_i(commit_cause),
    .commit_tval_i (tval_q),
    .restore_i     (restore),
    .rdata_o       (csrRdata),
    .mtvec_o       (mtvec),
    .mepc_o        (mepc),
    .mie_o         (mie)
  );

  assign take_evt     = validE & (exceptionE | iretE | (irqPending & mie));
  assign commit_cause = {kind_q == EV_IRQ, {(31 - CODE_W){1'b0}}, cause_q};
  // Vectored mode only applies to interrupts and only for mtvec[1:0]==01.
  assign vec_off      = (mtvec[1:0] == 2'b01 && kind_q == EV_IRQ)
                        ? {{(30 - CODE_W){1'b0}}, cause_q, 2'b00} : '0;
  assign trap_target  = (mtvec & 32'hFFFF_FFFC) + vec_off;

  always_comb begin
    kind_d  = kind_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    if (state_q == ST_IDLE && take_evt) begin
      kind_d  = exceptionE ? EV_EXC : (iretE ? EV_IRET : EV_IRQ);
      pc_d    = pcE;
      cause_d = exceptionE ? exceptionCodeE : irqCode;
      tval_d  = exceptionE ? trapValE : '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b1;
    stallF        = 1'b1;
    flushD        = 1'b1;
    flushE        = 1'b1;
    flushM        = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    commit        = 1'b0;
    restore       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy   = 1'b0;
        stallF = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (take_evt) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (memIdle) state_d = (kind_q == EV_IRET) ? ST_RESTORE : ST_COMMIT;
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_RESTORE: begin
        restore = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirectValid = 1'b1;
        flushM        = 1'b1;
        redirectPc    = (kind_q == EV_IRET) ? mepc : trap_target;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kind_q  <= EV_EXC;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized events vs a CSR-level model.
module tb_trap_controller;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        validE = 0, exceptionE = 0, iretE = 0, irqPending = 0, memIdle = 1, csrWe = 0;
  logic [31:0] pcE = 0, trapValE = 0, csrWdata = 0;
  logic [7:0]  exceptionCodeE = 0, irqCode = 0;
  logic [11:0] csrAddr = 0;
  logic [31:0] csrRdata, redirectPc;
  logic        busy, stallF, flushD, flushE, flushM, redirectValid;

  int n_cmp = 0, n_fail = 0;

  trap_controller dut (
    .clk(clk), .rst_n(rst_n), .validE(validE), .pcE(pcE), .exceptionE(exceptionE),
    .exceptionCodeE(exceptionCodeE), .trapValE(trapValE), .iretE(iretE),
    .irqPending(irqPending), .irqCode(irqCode), .memIdle(memIdle), .csrWe(csrWe),
    .csrAddr(csrAddr), .csrWdata(csrWdata), .csrRdata(csrRdata), .busy(busy),
    .stallF(stallF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .redirectValid(redirectValid), .redirectPc(redirectPc)
  );

  always #5 clk = ~clk;

  // Architectural model of the CSRs
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
  logic [11:0] addrs [5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343};

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
      12'h305: m_mtvec = d;
      12'h341: m_mepc = d - (d % 4);
      12'h342: m_mcause = d;
      12'h343: m_mtval = d;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_csr(input logic [11:0] a);
    case (a)
      12'h300: return (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  // kind: 0 exception, 1 interrupt, 2 return
  task automatic model_event(input int kind, input logic [31:0] pc, input logic [7:0] code,
                             input logic [31:0] tval, output logic [31:0] rpc);
    if (kind == 2) begin
      rpc = m_mepc; m_mie = m_mpie; m_mpie = 1;
    end else begin
      m_mepc   = pc - (pc % 4);
      m_mcause = (kind == 1 ? 32'h8000_0000 : 32'h0) + 32'(code);
      m_mtval  = (kind == 1) ? 32'h0 : tval;
      m_mpie   = m_mie; m_mie = 0;
      rpc = m_mtvec - (m_mtvec % 4) + ((kind == 1 && m_mtvec % 4 == 1) ? 32'(code) * 4 : 32'h0);
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); csrWe = 1; csrAddr = a; csrWdata = d;
    @(negedge clk); csrWe = 0;
    model_write(a, d);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csrAddr = a; #1; d = csrRdata;
  endtask

  // Presents one event for a cycle, holds memIdle low for stall_n DRAIN cycles,
  // returns cycles until redirect and whether stall/flush looked right in every busy cycle.
  task automatic run_event(input logic exc, iret, irq, input logic [31:0] pc,
                           input logic [7:0] ecode, icode, input logic [31:0] tval,
                           input int stall_n, output int lat, output logic [31:0] rpc, output bit ok);
    lat = 0; rpc = 0; ok = 1;
    @(negedge clk);
    validE = 1; exceptionE = exc; iretE = iret; irqPending = irq; pcE = pc;
    exceptionCodeE = ecode; irqCode = icode; trapValE = tval; memIdle = 1;
    @(negedge clk);
    validE = 0; exceptionE = 0; iretE = 0; irqPending = 0;
    for (int k = 1; k <= 40; k++) begin
      if (redirectValid) begin
        lat = k; rpc = redirectPc;
        if (!(busy && stallF && flushD && flushE && flushM)) ok = 0;
        break;
      end
      if (!(busy && stallF && flushD && flushE && !flushM)) ok = 0;
      memIdle = (k > stall_n);
      @(negedge clk);
    end
    memIdle = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, stallF, flushD, flushE, flushM, redirectValid, redirectPc} !== 38'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0",
                         {busy, stallF, flushD, flushE, flushM, redirectValid, redirectPc});
    end
    rst_n = 1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], v); n_cmp++;
      if (v !== model_csr(addrs[i])) begin
        n_fail++; $display("FAIL reset_csr_%h: got %h want %h", addrs[i], v, model_csr(addrs[i]));
      end
    end
  endtask

  task automatic test_exception();
    int lat; logic [31:0] rpc, exp_rpc, v; bit ok;
    csr_write(12'h300, 32'h8);
    run_event(1, 0, 0, 32'h80, 8'd2, 8'd0, 32'hDEAD, 0, lat, rpc, ok);
    model_event(0, 32'h80, 8'd2, 32'hDEAD, exp_rpc);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL exc_latency: got %0d want 3", lat); end
    n_cmp++; if (rpc !== exp_rpc) begin n_fail++; $display("FAIL exc_rpc: got %h want %h", rpc, exp_rpc); end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL exc_ctrl: got %b want 1", ok); end
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], v); n_cmp++;
      if (v !== model_csr(addrs[i])) begin
        n_fail++; $display("FAIL exc_csr_%h: got %h want %h", addrs[i], v, model_csr(addrs[i]));
      end
    end
  endtask

  task automatic test_vectored_irq();
    int lat; logic [31:0] rpc, exp_rpc, v; bit ok;
    csr_write(12'h305, 32'h201);
    csr_write(12'h300, 32'h8);
    run_event(0, 0, 1, 32'h1004, 8'd0, 8'd7, 32'h5555, 0, lat, rpc, ok);
    model_event(1, 32'h1004, 8'd7, 32'h5555, exp_rpc);
    n_cmp++; if (rpc !== 32'h21C) begin n_fail++; $display("FAIL irq_rpc: got %h want 0000021c", rpc); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL irq_latency: got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], v); n_cmp++;
      if (v !== model_csr(addrs[i])) begin
        n_fail++; $display("FAIL irq_csr_%h: got %h want %h", addrs[i], v, model_csr(addrs[i]));
      end
    end
    // masked interrupt must be ignored
    csr_write(12'h300, 32'h0);
    @(negedge clk); validE = 1; irqPending = 1;
    @(negedge clk); validE = 0; irqPending = 0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL irq_masked_busy: got %b want 0", busy); end
  endtask

  task automatic test_iret();
    int lat; logic [31:0] rpc, exp_rpc, v; bit ok;
    csr_write(12'h341, 32'h444);
    csr_write(12'h300, 32'h80);
    run_event(0, 1, 0, 32'h900, 8'd0, 8'd0, 32'h0, 0, lat, rpc, ok);
    model_event(2, 32'h900, 8'd0, 32'h0, exp_rpc);
    n_cmp++; if (rpc !== 32'h444) begin n_fail++; $display("FAIL iret_rpc: got %h want 00000444", rpc); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL iret_latency: got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], v); n_cmp++;
      if (v !== model_csr(addrs[i])) begin
        n_fail++; $display("FAIL iret_csr_%h: got %h want %h", addrs[i], v, model_csr(addrs[i]));
      end
    end
  endtask

  task automatic test_priority_drain();
    int lat; logic [31:0] rpc, exp_rpc, v; bit ok;
    csr_write(12'h305, 32'h301);
    csr_write(12'h300, 32'h8);
    run_event(1, 1, 1, 32'h2222, 8'd11, 8'd5, 32'hBEEF, 4, lat, rpc, ok);
    model_event(0, 32'h2222, 8'd11, 32'hBEEF, exp_rpc);
    n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL prio_latency: got %0d want 7", lat); end
    n_cmp++; if (rpc !== exp_rpc) begin n_fail++; $display("FAIL prio_rpc: got %h want %h", rpc, exp_rpc); end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL prio_ctrl: got %b want 1", ok); end
    rd(12'h342, v); n_cmp++;
    if (v !== 32'd11) begin n_fail++; $display("FAIL prio_mcause: got %h want 0000000b", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    csr_write(12'h300, 32'h8);
    csr_write(12'h305, 32'h201);
    csr_write(12'h341, 32'h444);
    @(negedge clk); validE = 1; exceptionE = 1; exceptionCodeE = 3; pcE = 32'h700; trapValE = 32'h77;
    @(negedge clk); validE = 0; exceptionE = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst_n = 0; #1;
    n_cmp++;
    if ({busy, stallF, flushD, flushE, flushM, redirectValid, redirectPc} !== 38'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h want 0",
                         {busy, stallF, flushD, flushE, flushM, redirectValid, redirectPc});
    end
    @(negedge clk); rst_n = 1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i], v); n_cmp++;
      if (v !== model_csr(addrs[i])) begin
        n_fail++; $display("FAIL rstmid_csr_%h: got %h want %h", addrs[i], v, model_csr(addrs[i]));
      end
    end
  endtask

  task automatic test_csr_write();
    logic [31:0] v, exp_rpc;
    csr_write(12'h341, 32'h123);
    rd(12'h341, v); n_cmp++;
    if (v !== 32'h120) begin n_fail++; $display("FAIL mepc_align: got %h want 00000120", v); end
    csr_write(12'h300, 32'h8);
    @(negedge clk); validE = 1; exceptionE = 1; exceptionCodeE = 4; pcE = 32'h500; trapValE = 32'h9;
    @(negedge clk); validE = 0; exceptionE = 0;
    @(negedge clk); csrWe = 1; csrAddr = 12'h300; csrWdata = 32'h0;
    @(negedge clk); csrWe = 0;
    model_event(0, 32'h500, 8'd4, 32'h9, exp_rpc);
    n_cmp++; if (redirectValid !== 1'b1) begin n_fail++; $display("FAIL commit_race_redirect: got %b want 1", redirectValid); end
    @(negedge clk);
    rd(12'h300, v); n_cmp++;
    if (v !== model_csr(12'h300)) begin n_fail++; $display("FAIL commit_race_mstatus: got %h want %h", v, model_csr(12'h300)); end
  endtask

  task automatic test_random();
    int lat, kind, stall_n; logic [31:0] rpc, exp_rpc, v, pc, tval; bit ok;
    logic e, r, q, vl; logic [7:0] ec, ic;
    for (int it = 0; it < 40; it++) begin
      csr_write(12'h300, $urandom);
      if ($urandom_range(0, 1)) csr_write(12'h305, $urandom);
      if ($urandom_range(0, 3) == 0) csr_write(12'h341, $urandom);
      e = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) == 0); q = $urandom_range(0, 1);
      vl = ($urandom_range(0, 4) != 0);
      ec = 8'($urandom); ic = 8'($urandom); pc = $urandom; tval = $urandom;
      stall_n = $urandom_range(0, 3);
      kind = e ? 0 : (r ? 2 : ((q && m_mie) ? 1 : -1));
      if (!vl || kind < 0) begin
        @(negedge clk); validE = vl; exceptionE = e; iretE = r; irqPending = q;
        @(negedge clk); validE = 0; exceptionE = 0; iretE = 0; irqPending = 0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_noevent_busy it%0d: got %b want 0", it, busy); end
        continue;
      end
      run_event(e, r, q, pc, ec, ic, tval, stall_n, lat, rpc, ok);
      model_event(kind, pc, kind == 1 ? ic : ec, tval, exp_rpc);
      n_cmp++; if (lat !== 3 + stall_n) begin n_fail++; $display("FAIL rnd_latency it%0d: got %0d want %0d", it, lat, 3 + stall_n); end
      n_cmp++; if (rpc !== exp_rpc) begin n_fail++; $display("FAIL rnd_rpc it%0d: got %h want %h", it, rpc, exp_rpc); end
      n_cmp++; if (ok !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_ctrl it%0d: got ok=%b busy=%b want ok=1 busy=0", it, ok, busy); end
      for (int i = 0; i < 5; i++) begin
        rd(addrs[i], v); n_cmp++;
        if (v !== model_csr(addrs[i])) begin
          n_fail++; $display("FAIL rnd_csr_%h it%0d: got %h want %h", addrs[i], it, v, model_csr(addrs[i]));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_exception();
    test_vectored_irq();
    test_iret();
    test_priority_drain();
    test_reset_mid();
    test_csr_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
